// File: rtl/ext_domain_power_seq.sv
// Power-domain sequencer for an external accelerator: ordered isolation/reset/switch
// control for power-off and power-on, optional RAM retention, switch-ack timeout.
module ext_domain_power_seq #(
  parameter int unsigned ISO_CYCLES  = 4,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic off_req_i,
  input  logic on_req_i,
  input  logic ret_req_i,
  input  logic busy_i,
  input  logic err_clr_i,
  output logic switch_on_o,
  input  logic switch_ack_i,
  output logic iso_o,
  output logic logic_rst_no,
  output logic ram_retentive_o,
  output logic powered_o,
  output logic done_o,
  output logic err_o
);

  localparam int unsigned MAXA = (ISO_CYCLES > RST_CYCLES) ? ISO_CYCLES : RST_CYCLES;
  localparam int unsigned MAXC = (MAXA > ACK_TIMEOUT) ? MAXA : ACK_TIMEOUT;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [3:0] {
    ON, ISO_ON, RST_ON, SW_OFF, OFF, SW_ON, RST_OFF, ISO_OFF, ERR
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ret_q, ret_d;
  logic          ack_s1_q, ack_s_q;

  logic          switch_on_q, switch_on_d;
  logic          iso_q, iso_d;
  logic          rst_n_q, rst_n_d;
  logic          ram_ret_q, ram_ret_d;
  logic          powered_q, powered_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  function automatic logic [CW-1:0] load_val(input state_e s);
    case (s)
      ISO_ON, ISO_OFF: load_val = CW'(ISO_CYCLES - 1);
      RST_ON, RST_OFF: load_val = CW'(RST_CYCLES - 1);
      SW_OFF, SW_ON:   load_val = CW'(ACK_TIMEOUT - 1);
      default:         load_val = '0;
    endcase
  endfunction

  // Switch status is asynchronous to clk_i; idle level is "supplied".
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_s1_q <= 1'b1;
      ack_s_q  <= 1'b1;
    end else begin
      ack_s1_q <= switch_ack_i;
      ack_s_q  <= ack_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    case (state_q)
      ON:      if (off_req_i && !busy_i) begin
                 state_d = ISO_ON;
                 ret_d   = ret_req_i;
               end
      ISO_ON:  if (cnt_q == '0) state_d = RST_ON;
      RST_ON:  if (cnt_q == '0) state_d = SW_OFF;
      SW_OFF:  if (!ack_s_q) state_d = OFF;
               else if (cnt_q == '0) state_d = ERR;
      OFF:     if (on_req_i) state_d = SW_ON;
      SW_ON:   if (ack_s_q) state_d = RST_OFF;
               else if (cnt_q == '0) state_d = ERR;
      RST_OFF: if (cnt_q == '0) state_d = ISO_OFF;
      ISO_OFF: if (cnt_q == '0) state_d = ON;
      ERR:     if (err_clr_i) state_d = SW_ON;
      default: state_d = ON;
    endcase
    if (state_d == ON || state_d == ERR) ret_d = 1'b0;

    // Loading on entry makes each timed state last exactly N cycles.
    if (state_d != state_q)   cnt_d = load_val(state_d);
    else if (cnt_q != '0)     cnt_d = cnt_q - 1'b1;
    else                      cnt_d = cnt_q;
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    switch_on_d = 1'b1;
    iso_d       = 1'b1;
    rst_n_d     = 1'b0;
    ram_ret_d   = 1'b0;
    powered_d   = 1'b0;
    err_d       = 1'b0;
    done_d      = (state_d != state_q) && (state_d == ON || state_d == OFF);
    case (state_d)
      ON:      begin iso_d = 1'b0; rst_n_d = 1'b1; powered_d = 1'b1; end
      ISO_ON:  begin rst_n_d = 1'b1; ram_ret_d = ret_d; end
      RST_ON:  ram_ret_d = ret_d;
      SW_OFF:  begin switch_on_d = 1'b0; ram_ret_d = ret_d; end
      OFF:     begin switch_on_d = 1'b0; ram_ret_d = ret_d; end
      SW_ON:   ram_ret_d = ret_d;
      RST_OFF: ;
      ISO_OFF: rst_n_d = 1'b1;
      ERR:     begin switch_on_d = 1'b0; err_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ON;
      cnt_q       <= '0;
      ret_q       <= 1'b0;
      switch_on_q <= 1'b1;
      iso_q       <= 1'b0;
      rst_n_q     <= 1'b1;
      ram_ret_q   <= 1'b0;
      powered_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ret_q       <= ret_d;
      switch_on_q <= switch_on_d;
      iso_q       <= iso_d;
      rst_n_q     <= rst_n_d;
      ram_ret_q   <= ram_ret_d;
      powered_q   <= powered_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign switch_on_o     = switch_on_q;
  assign iso_o           = iso_q;
  assign logic_rst_no    = rst_n_q;
  assign ram_retentive_o = ram_ret_q;
  assign powered_o       = powered_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_ext_domain_power_seq.sv
// Directed bench for ext_domain_power_seq; switch ack is modelled as switch_on_o
// delayed by three cycles, with an override forcing a stuck-supplied ack.
module tb_ext_domain_power_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic off_req, on_req, ret_req, busy, err_clr, ack_stuck;
  logic switch_on, switch_ack, iso, rst_no, ram_ret, powered, done, err;
  logic [2:0] ack_pipe = 3'b111;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  always @(negedge clk) ack_pipe <= {ack_pipe[1:0], switch_on};
  assign switch_ack = ack_stuck ? 1'b1 : ack_pipe[2];

  ext_domain_power_seq #(
    .ISO_CYCLES (4),
    .RST_CYCLES (4),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .off_req_i      (off_req),
    .on_req_i       (on_req),
    .ret_req_i      (ret_req),
    .busy_i         (busy),
    .err_clr_i      (err_clr),
    .switch_on_o    (switch_on),
    .switch_ack_i   (switch_ack),
    .iso_o          (iso),
    .logic_rst_no   (rst_no),
    .ram_retentive_o(ram_ret),
    .powered_o      (powered),
    .done_o         (done),
    .err_o          (err)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stepn(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  // Full off/on cycle from ON; cycle k = k-th posedge after off_req is raised.
  task automatic power_cycle(input logic ret);
    ret_req = ret;
    off_req = 1'b1;
    step();                                  // c1 ISO_ON
    chk("c1_iso", iso, 1'b1);
    chk("c1_sw", switch_on, 1'b1);
    chk("c1_rst", rst_no, 1'b1);
    chk("c1_pwr", powered, 1'b0);
    chk("c1_ret", ram_ret, ret);
    off_req = 1'b0;
    ret_req = 1'b0;
    stepn(3);                                // c4
    chk("c4_rst", rst_no, 1'b1);
    step();                                  // c5 RST_ON
    chk("c5_rst", rst_no, 1'b0);
    chk("c5_ret", ram_ret, ret);
    stepn(3);                                // c8
    chk("c8_sw", switch_on, 1'b1);
    step();                                  // c9 SW_OFF
    chk("c9_sw", switch_on, 1'b0);
    chk("c9_ret", ram_ret, ret);
    stepn(4);                                // c13
    chk("c13_done", done, 1'b0);
    step();                                  // c14 OFF
    chk("c14_done", done, 1'b1);
    chk("c14_pwr", powered, 1'b0);
    chk("c14_ret", ram_ret, ret);
    chk("c14_iso", iso, 1'b1);
    step();                                  // c15
    chk("c15_done", done, 1'b0);
    on_req = 1'b1;
    step();                                  // c16 SW_ON
    chk("c16_sw", switch_on, 1'b1);
    chk("c16_ret", ram_ret, ret);
    on_req = 1'b0;
    stepn(5);                                // c21 RST_OFF
    chk("c21_rst", rst_no, 1'b0);
    chk("c21_ret", ram_ret, 1'b0);
    stepn(3);                                // c24
    chk("c24_rst", rst_no, 1'b0);
    step();                                  // c25 ISO_OFF
    chk("c25_rst", rst_no, 1'b1);
    chk("c25_iso", iso, 1'b1);
    stepn(3);                                // c28
    chk("c28_iso", iso, 1'b1);
    step();                                  // c29 ON
    chk("c29_iso", iso, 1'b0);
    chk("c29_pwr", powered, 1'b1);
    chk("c29_done", done, 1'b1);
    step();
    chk("c30_done", done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; off_req = 1'b0; on_req = 1'b0; ret_req = 1'b0;
    busy = 1'b0; err_clr = 1'b0; ack_stuck = 1'b0;
    #12;
    chk("rst_sw", switch_on, 1'b1);
    chk("rst_iso", iso, 1'b0);
    chk("rst_lrst", rst_no, 1'b1);
    chk("rst_ret", ram_ret, 1'b0);
    chk("rst_pwr", powered, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    stepn(2);

    power_cycle(1'b0);

    // Busy blocks power-off; on_req in ON is ignored.
    busy = 1'b1; off_req = 1'b1; on_req = 1'b1;
    stepn(20);
    chk("busy_iso", iso, 1'b0);
    chk("busy_pwr", powered, 1'b1);
    on_req = 1'b0;
    busy = 1'b0;
    power_cycle(1'b1);

    // Stuck ack during power-off: SW_OFF c9..c24, ERR at c25.
    ack_stuck = 1'b1;
    off_req = 1'b1;
    step();
    off_req = 1'b0;
    stepn(23);                               // c24
    chk("to_err_early", err, 1'b0);
    step();                                  // c25 ERR
    chk("to_err", err, 1'b1);
    chk("to_sw", switch_on, 1'b0);
    chk("to_iso", iso, 1'b1);
    chk("to_rst", rst_no, 1'b0);
    err_clr = 1'b1;
    step();                                  // c26 SW_ON
    err_clr = 1'b0;
    chk("clr_err", err, 1'b0);
    chk("clr_sw", switch_on, 1'b1);
    step();                                  // c27 RST_OFF
    chk("clr_rst0", rst_no, 1'b0);
    stepn(4);                                // c31 ISO_OFF
    chk("clr_rst1", rst_no, 1'b1);
    chk("clr_pwr_early", powered, 1'b0);
    stepn(4);                                // c35 ON
    chk("clr_pwr", powered, 1'b1);
    chk("clr_done", done, 1'b1);
    chk("clr_iso", iso, 1'b0);
    ack_stuck = 1'b0;
    stepn(2);

    // Asynchronous reset during RST_ON.
    off_req = 1'b1;
    step();
    off_req = 1'b0;
    stepn(4);                                // c5 RST_ON
    chk("ar_pre_rst", rst_no, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sw", switch_on, 1'b1);
    chk("ar_iso", iso, 1'b0);
    chk("ar_rst", rst_no, 1'b1);
    chk("ar_err", err, 1'b0);
    chk("ar_pwr", powered, 1'b1);
    #3 rst_n = 1'b1;
    stepn(3);
    chk("ar_hold_iso", iso, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
